// File: rtl/alu_execute.sv
// Execute-stage ALU: arithmetic/logic, load-extension and shift operations
// on the preprocessed operand bundle, with a one-cycle registered result,
// carry, overflow, sticky overflow status and a result_valid strobe.
module alu_execute #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] aluin1,
    input  logic [WIDTH-1:0] aluin2,
    input  logic [2:0]       operation_in,
    input  logic [2:0]       opselect_in,
    input  logic [4:0]       shift_number,
    input  logic             enable_arith,
    input  logic             enable_shift,
    input  logic             clr_status,
    output logic [WIDTH-1:0] aluout,
    output logic             carry,
    output logic             overflow,
    output logic             sticky_overflow,
    output logic             result_valid
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned BYTE = 8;

    // Operation class carried on opselect_in
    typedef enum logic [2:0] {
        SEL_SHIFT = 3'b000,
        SEL_ARITH = 3'b001,
        SEL_WRITE = 3'b100,
        SEL_READ  = 3'b101
    } opsel_t;

    // Arithmetic/logic operation codes
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_HADD = 3'b001,
        OP_SUB  = 3'b010,
        OP_NOT  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_LHG  = 3'b111
    } alu_op_t;

    // Memory-read extension codes
    typedef enum logic [2:0] {
        LD_SB = 3'b000,
        LD_SH = 3'b001,
        LD_W  = 3'b011,
        LD_UB = 3'b100,
        LD_UH = 3'b101
    } ld_op_t;

    // Shift codes
    typedef enum logic [2:0] {
        SH_LL0 = 3'b000,
        SH_LL1 = 3'b001,
        SH_LR  = 3'b010,
        SH_AR  = 3'b011
    } sh_op_t;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [HALF:0]    hsum;
    logic             add_ovf;
    logic             sub_ovf;

    logic             load;
    logic [WIDTH-1:0] next_result;
    logic             next_carry;
    logic             next_overflow;
    logic             next_sticky;

    assign sum_ext = {1'b0, aluin1} + {1'b0, aluin2};
    assign diff    = aluin1 - aluin2;
    assign hsum    = {1'b0, aluin1[HALF-1:0]} + {1'b0, aluin2[HALF-1:0]};

    // Signed overflow: operands alike (add) / unlike (sub) and result sign flips
    assign add_ovf = (aluin1[WIDTH-1] == aluin2[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != aluin1[WIDTH-1]);
    assign sub_ovf = (aluin1[WIDTH-1] != aluin2[WIDTH-1]) &&
                     (diff[WIDTH-1] != aluin1[WIDTH-1]);

    // Decode the enabled operation into the next result and flags
    always_comb begin
        load          = 1'b0;
        next_result   = aluout;
        next_carry    = carry;
        next_overflow = overflow;

        if (enable_arith) begin
            case (opselect_in)
                SEL_ARITH: begin
                    load          = 1'b1;
                    next_carry    = 1'b0;
                    next_overflow = 1'b0;
                    case (operation_in)
                        OP_ADD: begin
                            next_result   = sum_ext[WIDTH-1:0];
                            next_carry    = sum_ext[WIDTH];
                            next_overflow = add_ovf;
                        end
                        OP_HADD: begin
                            next_result = {{(WIDTH-HALF){hsum[HALF-1]}}, hsum[HALF-1:0]};
                            next_carry  = hsum[HALF];
                        end
                        OP_SUB: begin
                            next_result   = diff;
                            next_carry    = (aluin1 < aluin2);
                            next_overflow = sub_ovf;
                        end
                        OP_NOT: next_result = ~aluin2;
                        OP_AND: next_result = aluin1 & aluin2;
                        OP_OR:  next_result = aluin1 | aluin2;
                        OP_XOR: next_result = aluin1 ^ aluin2;
                        OP_LHG: next_result = {aluin2[HALF-1:0], {(WIDTH-HALF){1'b0}}};
                        default: next_result = aluout;
                    endcase
                end
                SEL_READ: begin
                    load          = 1'b1;
                    next_carry    = 1'b0;
                    next_overflow = 1'b0;
                    case (operation_in)
                        LD_SB:   next_result = {{(WIDTH-BYTE){aluin2[BYTE-1]}}, aluin2[BYTE-1:0]};
                        LD_UB:   next_result = {{(WIDTH-BYTE){1'b0}}, aluin2[BYTE-1:0]};
                        LD_SH:   next_result = {{(WIDTH-HALF){aluin2[HALF-1]}}, aluin2[HALF-1:0]};
                        LD_UH:   next_result = {{(WIDTH-HALF){1'b0}}, aluin2[HALF-1:0]};
                        LD_W:    next_result = aluin2;
                        default: next_result = '0;
                    endcase
                end
                default: load = 1'b0;
            endcase
        end else if (enable_shift && (opselect_in == SEL_SHIFT)) begin
            case (operation_in)
                SH_LL0, SH_LL1: begin
                    load        = 1'b1;
                    next_result = aluin1 << shift_number;
                end
                SH_LR: begin
                    load        = 1'b1;
                    next_result = aluin1 >> shift_number;
                end
                SH_AR: begin
                    load        = 1'b1;
                    next_result = $signed(aluin1) >>> shift_number;
                end
                default: load = 1'b0;
            endcase
            if (load) begin
                next_carry    = 1'b0;
                next_overflow = 1'b0;
            end
        end
    end

    // Sticky status: a fresh overflow beats a simultaneous clear
    always_comb begin
        next_sticky = sticky_overflow;
        if (load && next_overflow) begin
            next_sticky = 1'b1;
        end else if (clr_status) begin
            next_sticky = 1'b0;
        end
    end

    // Result and status registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluout          <= '0;
            carry           <= 1'b0;
            overflow        <= 1'b0;
            sticky_overflow <= 1'b0;
            result_valid    <= 1'b0;
        end else begin
            aluout          <= next_result;
            carry           <= next_carry;
            overflow        <= next_overflow;
            sticky_overflow <= next_sticky;
            result_valid    <= load;
        end
    end

endmodule

// File: tb/tb_alu_execute.sv
// Directed self-checking bench for alu_execute.
module tb_alu_execute;

    logic        clock;
    logic        reset;
    logic [31:0] aluin1;
    logic [31:0] aluin2;
    logic [2:0]  operation_in;
    logic [2:0]  opselect_in;
    logic [4:0]  shift_number;
    logic        enable_arith;
    logic        enable_shift;
    logic        clr_status;
    logic [31:0] aluout;
    logic        carry;
    logic        overflow;
    logic        sticky_overflow;
    logic        result_valid;

    int checks;
    int failures;

    alu_execute #(.WIDTH(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .aluin1          (aluin1),
        .aluin2          (aluin2),
        .operation_in    (operation_in),
        .opselect_in     (opselect_in),
        .shift_number    (shift_number),
        .enable_arith    (enable_arith),
        .enable_shift    (enable_shift),
        .clr_status      (clr_status),
        .aluout          (aluout),
        .carry           (carry),
        .overflow        (overflow),
        .sticky_overflow (sticky_overflow),
        .result_valid    (result_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ea, input logic es, input logic [2:0] sel,
                         input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        enable_arith = ea;
        enable_shift = es;
        opselect_in  = sel;
        operation_in = op;
        aluin1       = a;
        aluin2       = b;
        shift_number = sh;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 3'b000, 32'h0, 32'h0, 5'd0);
        clr_status = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #12;
        checks++; if (aluout !== 32'h0) begin failures++; $display("FAIL reset_aluout got=%h exp=%h", aluout, 32'h0); end
        checks++; if ({carry, overflow, sticky_overflow, result_valid} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=%b", {carry, overflow, sticky_overflow, result_valid}, 4'b0000); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 3'b001, 3'b000, 32'h12345670, 32'h8, 5'd0);
        tick();
        checks++; if (aluout !== 32'h12345678) begin failures++; $display("FAIL preload_aluout got=%h exp=%h", aluout, 32'h12345678); end
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL preload_valid got=%b exp=1", result_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (aluout !== 32'h0) begin failures++; $display("FAIL async_reset_aluout got=%h exp=%h", aluout, 32'h0); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", result_valid); end
        idle();
        #2 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (aluout !== 32'h0 || result_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%h/%b exp=%h/0", aluout, result_valid, 32'h0); end
        end
    endtask

    task automatic test_add_sub();
        drive(1'b1, 1'b0, 3'b001, 3'b000, 32'h7FFFFFFF, 32'h1, 5'd0);
        tick();
        checks++; if (aluout !== 32'h80000000) begin failures++; $display("FAIL add_ovf_out got=%h exp=%h", aluout, 32'h80000000); end
        checks++; if ({carry, overflow, sticky_overflow, result_valid} !== 4'b0111) begin failures++; $display("FAIL add_ovf_flags got=%b exp=%b", {carry, overflow, sticky_overflow, result_valid}, 4'b0111); end
        drive(1'b1, 1'b0, 3'b001, 3'b010, 32'h5, 32'h7, 5'd0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checks++; if (aluout !== 32'hFFFFFFFE) begin failures++; $display("FAIL sub_borrow_out got=%h exp=%h", aluout, 32'hFFFFFFFE); end
        checks++; if ({carry, overflow, sticky_overflow, result_valid} !== 4'b1001) begin failures++; $display("FAIL sub_borrow_flags got=%b exp=%b", {carry, overflow, sticky_overflow, result_valid}, 4'b1001); end
        drive(1'b1, 1'b0, 3'b001, 3'b000, 32'hFFFFFFFF, 32'h2, 5'd0);
        tick();
        checks++; if (aluout !== 32'h1 || {carry, overflow} !== 2'b10) begin failures++; $display("FAIL add_carry got=%h/%b exp=%h/%b", aluout, {carry, overflow}, 32'h1, 2'b10); end
    endtask

    task automatic test_logic();
        logic [2:0]  ops [4];
        logic [31:0] exp [4];
        ops = '{3'b100, 3'b101, 3'b110, 3'b011};
        exp = '{32'h00F01200, 32'hFFF0FF34, 32'hFF00ED34, 32'hF00F00FF};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 3'b001, ops[i], 32'hF0F01234, 32'h0FF0FF00, 5'd0);
            tick();
            checks++; if (aluout !== exp[i] || {carry, overflow, result_valid} !== 3'b001) begin failures++; $display("FAIL logic_op%0d got=%h/%b exp=%h/%b", i, aluout, {carry, overflow, result_valid}, exp[i], 3'b001); end
        end
    endtask

    task automatic test_mem_read();
        logic [2:0]  ops [6];
        logic [31:0] exp [6];
        ops = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011, 3'b010};
        exp = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h000080F0, 32'h000080F0, 32'h00000000};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 3'b101, ops[i], 32'hDEADBEEF, 32'h000080F0, 5'd0);
            tick();
            checks++; if (aluout !== exp[i] || result_valid !== 1'b1) begin failures++; $display("FAIL memrd_op%0d got=%h/%b exp=%h/1", i, aluout, result_valid, exp[i]); end
        end
        drive(1'b1, 1'b0, 3'b100, 3'b000, 32'h11111111, 32'h22222222, 5'd0);
        tick();
        checks++; if (aluout !== 32'h00000000 || result_valid !== 1'b0) begin failures++; $display("FAIL memwr_noop got=%h/%b exp=%h/0", aluout, result_valid, 32'h0); end
    endtask

    task automatic test_shift();
        logic [2:0]  ops [3];
        logic [31:0] exp [3];
        ops = '{3'b000, 3'b010, 3'b011};
        exp = '{32'h00000100, 32'h08000001, 32'hF8000001};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 3'b000, ops[i], 32'h80000010, 32'h0, 5'd4);
            tick();
            checks++; if (aluout !== exp[i] || result_valid !== 1'b1) begin failures++; $display("FAIL shift_op%0d got=%h/%b exp=%h/1", i, aluout, result_valid, exp[i]); end
        end
        drive(1'b0, 1'b1, 3'b000, 3'b001, 32'h80000010, 32'h0, 5'd0);
        tick();
        checks++; if (aluout !== 32'h80000010) begin failures++; $display("FAIL shift_zero got=%h exp=%h", aluout, 32'h80000010); end
        drive(1'b0, 1'b1, 3'b000, 3'b100, 32'h12345678, 32'h0, 5'd1);
        tick();
        checks++; if (aluout !== 32'h80000010 || result_valid !== 1'b0) begin failures++; $display("FAIL shift_badop got=%h/%b exp=%h/0", aluout, result_valid, 32'h80000010); end
        drive(1'b0, 1'b1, 3'b001, 3'b000, 32'h12345678, 32'h0, 5'd1);
        tick();
        checks++; if (aluout !== 32'h80000010 || result_valid !== 1'b0) begin failures++; $display("FAIL shift_badsel got=%h/%b exp=%h/0", aluout, result_valid, 32'h80000010); end
    endtask

    task automatic test_hadd_lhg();
        drive(1'b1, 1'b0, 3'b001, 3'b001, 32'h0000FFFF, 32'h1, 5'd0);
        tick();
        checks++; if (aluout !== 32'h0 || {carry, overflow} !== 2'b10) begin failures++; $display("FAIL hadd_carry got=%h/%b exp=%h/%b", aluout, {carry, overflow}, 32'h0, 2'b10); end
        drive(1'b1, 1'b0, 3'b001, 3'b001, 32'h00007FFF, 32'h1, 5'd0);
        tick();
        checks++; if (aluout !== 32'hFFFF8000 || {carry, overflow} !== 2'b00) begin failures++; $display("FAIL hadd_sext got=%h/%b exp=%h/%b", aluout, {carry, overflow}, 32'hFFFF8000, 2'b00); end
        drive(1'b1, 1'b0, 3'b001, 3'b111, 32'h0, 32'h0000ABCD, 5'd0);
        tick();
        checks++; if (aluout !== 32'hABCD0000 || carry !== 1'b0) begin failures++; $display("FAIL lhg got=%h/%b exp=%h/0", aluout, carry, 32'hABCD0000); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 3'b001, 3'b000, 32'h2, 32'h3, 5'd3);
        tick();
        checks++; if (aluout !== 32'h5 || result_valid !== 1'b1) begin failures++; $display("FAIL both_enables got=%h/%b exp=%h/1", aluout, result_valid, 32'h5); end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (aluout !== 32'h5 || result_valid !== 1'b0) begin failures++; $display("FAIL idle_hold%0d got=%h/%b exp=%h/0", i, aluout, result_valid, 32'h5); end
        end
        drive(1'b1, 1'b0, 3'b001, 3'b010, 32'h80000000, 32'h1, 5'd0);
        clr_status = 1'b1;
        tick();
        checks++; if (aluout !== 32'h7FFFFFFF) begin failures++; $display("FAIL sub_ovf_out got=%h exp=%h", aluout, 32'h7FFFFFFF); end
        checks++; if ({carry, overflow, sticky_overflow} !== 3'b011) begin failures++; $display("FAIL set_wins got=%b exp=%b", {carry, overflow, sticky_overflow}, 3'b011); end
        idle();
        tick();
        checks++; if ({overflow, sticky_overflow, result_valid} !== 3'b110) begin failures++; $display("FAIL idle_flags_hold got=%b exp=%b", {overflow, sticky_overflow, result_valid}, 3'b110); end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checks++; if ({overflow, sticky_overflow} !== 2'b10) begin failures++; $display("FAIL clr_sticky got=%b exp=%b", {overflow, sticky_overflow}, 2'b10); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_async_reset();
        test_add_sub();
        test_logic();
        test_mem_read();
        test_shift();
        test_hadd_lhg();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
